kernel_window_buffer: RTL and testbench
=======================================

# kernel_window_buffer

Assembles the n×n pixel neighbourhood consumed by the weighted-order-statistics sorter from the pixel stream read out of image memory under control of `address_handler`. Sits directly downstream of `address_handler`: it samples memory read data on each `kernel_clk` strobe, builds columns, shifts them into a MAX_N×MAX_N window register and presents a complete window to the sorter with a valid/ready handshake.

## Interface
- `WORD`, 8, pixel width in bits
- `MAX_N`, 3, maximum kernel side; window storage is MAX_N×MAX_N

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `n`  in  8  active kernel side, 1..MAX_N; sampled on `kernel_newline`
- `pixel_in`  in  WORD  memory read data, valid when `kernel_clk`=1
- `kernel_clk`  in  1  one-cycle strobe: one pixel of the current column on `pixel_in`
- `kernel_newline`  in  1  one-cycle strobe: new kernel row starts, discard window contents
- `kernel_running`  in  1  high while `address_handler` is scanning
- `window`  out  MAX_N*MAX_N*WORD  window, element (r,c) at bits [(r*MAX_N+c)*WORD +: WORD], c=0 oldest column
- `window_valid`  out  1  window complete, held until accepted
- `window_ready`  in  1  sorter accepts when `window_valid`&`window_ready`
- `busy`  out  1  FILL or STREAM state

## Operation
- Pixels arrive column-major, top to bottom, n pixels per column. `row_cnt` counts 0..n-1; on the n-th pixel the column is complete.
- Column completion: window shifts left one column (c ← c+1), new column written at c=n-1; elements with r≥n or c≥n forced to 0.
- `col_cnt` (0..n, saturating) counts completed columns since last `kernel_newline`.
- States: IDLE → FILL on `kernel_newline`; FILL → STREAM when `col_cnt` reaches n; STREAM → FILL on `kernel_newline`; any state → IDLE when `kernel_running`=0 and no window pending.
- Valid: set on each column completion with `col_cnt`≥n after the update (i.e. the n-th and each later column); cleared on handshake.
- `kernel_newline`: clears `row_cnt`, `col_cnt`, window registers, latches `n`. If it coincides with `kernel_clk`, newline takes effect first and the pixel becomes row 0 of column 0.
- Pending valid is not cleared by `kernel_newline`; the latched `window` output is a separate register copied at valid set, so newline does not corrupt a pending window.
- Column completion while `window_valid`=1 and not accepted in that cycle: new window dropped, pending window kept (overflow, see Configuration). Handshake and completion in the same cycle: new window loaded, valid stays 1.
- `n`=0 or `n`>MAX_N treated as MAX_N.

## Timing
- Reset: state IDLE, counters 0, window registers and `window` all 0, `window_valid`=0, `busy`=0.
- Latency: `window_valid` rises the cycle after the `kernel_clk` carrying the last pixel of the completing column.
- Throughput: one pixel per cycle; `kernel_clk` may be high every cycle.
- Reset assertion mid-operation: all state cleared immediately, no partial window emitted.

## Configuration
- `WINDOW_OVERFLOW_EN` defined: adds output `overflow` (1 bit), sticky, set when a window is dropped per the rule above, cleared only by reset or `kernel_newline`. Undefined: port absent, drops silent.

## Structure
- Shared package `filter_pkg`: `WORD`, `MAX_N` defaults, state enum {IDLE, FILL, STREAM}, window index helper constant `WIN_BITS = MAX_N*MAX_N*WORD`.
- One sub-module `column_collector`: `row_cnt`, column shift-in register, `col_done` pulse; top holds window array, FSM and handshake.

## Test plan
- n=3, newline, pixels 1..9 on consecutive strobes, ready=1 → valid one cycle after pixel 9, window rows {1,4,7},{2,5,8},{3,6,9}.
- Continue pixels 10..12 → second valid, columns {4..6},{7..9},{10..12}.
- n=2 with MAX_N=3, pixels 1..4 → valid, elements with r=2 or c=2 are 0.
- ready=0 while two further columns complete → first window held unchanged, `overflow`=1 when `WINDOW_OVERFLOW_EN` defined.
- Newline coinciding with kernel_clk after 5 pixels → pixel treated as row 0 col 0; no valid until 9 more pixels.
- rst low mid-FILL → all outputs 0 next edge; after release, full 9-pixel fill required.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants and types for the kernel window datapath feeding the order-statistics sorter.
package filter_pkg;

    localparam int unsigned WORD     = 8;
    localparam int unsigned MAX_N    = 3;
    localparam int unsigned WIN_BITS = MAX_N * MAX_N * WORD;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStream
    } state_e;

endpackage

// File: rtl/column_collector.sv
// Collects n pixels of one kernel column; col_done_o pulses in the cycle the last pixel arrives,
// with col_o already holding that pixel so the window can absorb it on the same edge.
module column_collector
    import filter_pkg::*;
#(
    parameter int unsigned Word = WORD,
    parameter int unsigned MaxN = MAX_N
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           n_i,
    input  logic [Word-1:0]      pixel_i,
    input  logic                 kernel_clk_i,
    input  logic                 newline_i,
    output logic [MaxN*Word-1:0] col_o,
    output logic                 col_done_o
);

    logic [7:0]      row_cnt_q, row_cnt_d, row_idx;
    logic [Word-1:0] col_q [MaxN];
    logic [Word-1:0] col_d [MaxN];

    always_comb begin
        // A newline coinciding with a strobe makes this pixel row 0 of a fresh column.
        row_idx    = newline_i ? 8'd0 : row_cnt_q;
        col_done_o = kernel_clk_i && (row_idx == n_i - 8'd1);
        row_cnt_d  = row_idx;
        if (kernel_clk_i) begin
            row_cnt_d = col_done_o ? 8'd0 : row_idx + 8'd1;
        end
        for (int unsigned r = 0; r < MaxN; r++) begin
            col_d[r] = newline_i ? '0 : col_q[r];
            if (kernel_clk_i && (row_idx == 8'(r))) begin
                col_d[r] = pixel_i;
            end
            col_o[r*Word +: Word] = (8'(r) < n_i) ? col_d[r] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_cnt_q <= 8'd0;
            for (int unsigned r = 0; r < MaxN; r++) begin
                col_q[r] <= '0;
            end
        end else begin
            row_cnt_q <= row_cnt_d;
            for (int unsigned r = 0; r < MaxN; r++) begin
                col_q[r] <= col_d[r];
            end
        end
    end

endmodule

// File: rtl/kernel_window_buffer.sv
// Builds the n x n pixel window for the sorter and hands it over with valid/ready.
// Optional sticky overflow output when WINDOW_OVERFLOW_EN is defined.
module kernel_window_buffer
    import filter_pkg::*;
#(
    parameter int unsigned Word = WORD,
    parameter int unsigned MaxN = MAX_N
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [7:0]                n_i,
    input  logic [Word-1:0]           pixel_i,
    input  logic                      kernel_clk_i,
    input  logic                      kernel_newline_i,
    input  logic                      kernel_running_i,
    output logic [MaxN*MaxN*Word-1:0] window_o,
    output logic                      window_valid_o,
    output logic                      busy_o,
`ifdef WINDOW_OVERFLOW_EN
    output logic                      overflow_o,
`endif
    input  logic                      window_ready_i
);

    state_e state_q, state_d;
    logic [7:0] n_q, n_d, n_san, n_eff;
    logic [7:0] col_cnt_q, col_cnt_d, cnt_base;
    logic [31:0] n_int;
    logic [Word-1:0] win_q    [MaxN][MaxN];
    logic [Word-1:0] win_d    [MaxN][MaxN];
    logic [Word-1:0] win_base [MaxN][MaxN];
    logic [MaxN*MaxN*Word-1:0] window_q, window_d;
    logic valid_q, valid_d;
    logic ovf_q, ovf_d;
    logic [MaxN*Word-1:0] col;
    logic col_done, new_win, accept, drop;

    // Out-of-range kernel sides fall back to the full window.
    assign n_san = ((n_i == 8'd0) || (n_i > 8'(MaxN))) ? 8'(MaxN) : n_i;
    assign n_eff = kernel_newline_i ? n_san : n_q;
    assign n_int = {24'd0, n_eff};

    column_collector #(
        .Word (Word),
        .MaxN (MaxN)
    ) u_column_collector (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .n_i          (n_eff),
        .pixel_i      (pixel_i),
        .kernel_clk_i (kernel_clk_i),
        .newline_i    (kernel_newline_i),
        .col_o        (col),
        .col_done_o   (col_done)
    );

    always_comb begin
        n_d       = n_eff;
        cnt_base  = kernel_newline_i ? 8'd0 : col_cnt_q;
        col_cnt_d = cnt_base;
        for (int unsigned r = 0; r < MaxN; r++) begin
            for (int unsigned c = 0; c < MaxN; c++) begin
                win_base[r][c] = kernel_newline_i ? '0 : win_q[r][c];
                win_d[r][c]    = win_base[r][c];
            end
        end
        if (col_done) begin
            col_cnt_d = (cnt_base >= n_eff) ? n_eff : cnt_base + 8'd1;
            for (int unsigned r = 0; r < MaxN; r++) begin
                for (int unsigned c = 0; c < MaxN; c++) begin
                    if ((r < n_int) && (c < n_int)) begin
                        win_d[r][c] = (c == n_int - 1) ? col[r*Word +: Word]
                                                       : win_base[r][(c + 1) % MaxN];
                    end else begin
                        win_d[r][c] = '0;
                    end
                end
            end
        end

        new_win  = col_done && (col_cnt_d >= n_eff);
        accept   = valid_q && window_ready_i;
        valid_d  = valid_q;
        window_d = window_q;
        drop     = 1'b0;
        if (accept) begin
            valid_d = 1'b0;
        end
        // The presented window is a separate copy, so a pending one survives newline and drops.
        if (new_win) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                for (int unsigned r = 0; r < MaxN; r++) begin
                    for (int unsigned c = 0; c < MaxN; c++) begin
                        window_d[(r*MaxN+c)*Word +: Word] = win_d[r][c];
                    end
                end
            end else begin
                drop = 1'b1;
            end
        end

        ovf_d = kernel_newline_i ? 1'b0 : ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (kernel_newline_i) begin
                    state_d = (col_cnt_d >= n_eff) ? StStream : StFill;
                end
            end
            StFill: begin
                if (col_cnt_d >= n_eff) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (kernel_newline_i) begin
                    state_d = (col_cnt_d >= n_eff) ? StStream : StFill;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!kernel_running_i && !valid_d && !kernel_newline_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            n_q       <= 8'(MaxN);
            col_cnt_q <= 8'd0;
            window_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            for (int unsigned r = 0; r < MaxN; r++) begin
                for (int unsigned c = 0; c < MaxN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            col_cnt_q <= col_cnt_d;
            window_q  <= window_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            for (int unsigned r = 0; r < MaxN; r++) begin
                for (int unsigned c = 0; c < MaxN; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    assign window_o       = window_q;
    assign window_valid_o = valid_q;
    assign busy_o         = (state_q != StIdle);
`ifdef WINDOW_OVERFLOW_EN
    assign overflow_o     = ovf_q;
`endif

endmodule

// File: tb/tb_kernel_window_buffer.sv
// Scoreboard bench for kernel_window_buffer; expected windows come from the pixel numbering.
module tb_kernel_window_buffer;
    import filter_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          n;
    logic [WORD-1:0]     pixel;
    logic                kernel_clk, kernel_newline, kernel_running, window_ready;
    logic [WIN_BITS-1:0] window;
    logic                window_valid, busy;
`ifdef WINDOW_OVERFLOW_EN
    logic                overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIN_BITS-1:0] sb_q[$];

    always #5 clk = ~clk;

    kernel_window_buffer u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .n_i              (n),
        .pixel_i          (pixel),
        .kernel_clk_i     (kernel_clk),
        .kernel_newline_i (kernel_newline),
        .kernel_running_i (kernel_running),
        .window_o         (window),
        .window_valid_o   (window_valid),
        .busy_o           (busy),
`ifdef WINDOW_OVERFLOW_EN
        .overflow_o       (overflow),
`endif
        .window_ready_i   (window_ready)
    );

    task automatic check_eq(input string tag, input logic [WIN_BITS-1:0] got,
                            input logic [WIN_BITS-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pixels numbered v0, v0+1, ... column-major; window after column k holds columns k-n+1..k.
    function automatic logic [WIN_BITS-1:0] exp_win(input int nn, input int v0, input int k);
        logic [WIN_BITS-1:0] w;
        w = '0;
        for (int r = 0; r < nn; r++) begin
            for (int c = 0; c < nn; c++) begin
                w[(r*MAX_N+c)*WORD +: WORD] = WORD'(v0 + (k - nn + 1 + c) * nn + r);
            end
        end
        return w;
    endfunction

    task automatic drive_px(input int v, input logic nl);
        pixel          = WORD'(v);
        kernel_clk     = 1'b1;
        kernel_newline = nl;
        @(posedge clk);
        #1;
        kernel_clk     = 1'b0;
        kernel_newline = 1'b0;
    endtask

    task automatic run_pixels(input int v0, input int count, input logic first_nl);
        for (int i = 0; i < count; i++) begin
            drive_px(v0 + i, first_nl && (i == 0));
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && window_valid && window_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_window", WIN_BITS'(sb_q.size()), 1);
            end else begin
                check_eq("window", window, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; n = 8'd3; pixel = '0; kernel_clk = 1'b0; kernel_newline = 1'b0;
        kernel_running = 1'b0; window_ready = 1'b1;
        idle(2);
        check_eq("rst_window", window, '0);
        check_eq("rst_valid", window_valid, 0);
        check_eq("rst_busy", busy, 0);
`ifdef WINDOW_OVERFLOW_EN
        check_eq("rst_overflow", overflow, 0);
`endif
        rst_n = 1'b1;
        idle(1);
        kernel_running = 1'b1;

        // n=3, first window
        run_pixels(1, 8, 1'b1);
        check_eq("no_early_valid", window_valid, 0);
        check_eq("busy_fill", busy, 1);
        sb_q.push_back(exp_win(3, 1, 2));
        drive_px(9, 1'b0);
        check_eq("latency_first", window_valid, 1);

        // streaming column 4
        run_pixels(10, 2, 1'b0);
        sb_q.push_back(exp_win(3, 1, 3));
        drive_px(12, 1'b0);
        check_eq("latency_stream", window_valid, 1);
        idle(1);

        // n=2 inside a 3x3 store
        n = 8'd2;
        run_pixels(1, 3, 1'b1);
        sb_q.push_back(exp_win(2, 1, 1));
        drive_px(4, 1'b0);
        check_eq("latency_n2", window_valid, 1);
        idle(1);

        // backpressure: two more columns dropped while first window pending
        n = 8'd3;
        window_ready = 1'b0;
        run_pixels(21, 8, 1'b1);
        sb_q.push_back(exp_win(3, 21, 2));
        drive_px(29, 1'b0);
        run_pixels(30, 6, 1'b0);
        check_eq("held_window", window, exp_win(3, 21, 2));
        check_eq("held_valid", window_valid, 1);
`ifdef WINDOW_OVERFLOW_EN
        check_eq("overflow_set", overflow, 1);
`endif
        window_ready = 1'b1;
        idle(1);
        check_eq("valid_cleared", window_valid, 0);
        check_eq("sb_after_ovf", WIN_BITS'(sb_q.size()), 0);

        // newline coinciding with a strobe after 5 pixels
        run_pixels(41, 5, 1'b1);
`ifdef WINDOW_OVERFLOW_EN
        check_eq("overflow_cleared", overflow, 0);
`endif
        drive_px(50, 1'b1);
        run_pixels(51, 7, 1'b0);
        check_eq("nl_no_valid", window_valid, 0);
        sb_q.push_back(exp_win(3, 50, 2));
        drive_px(58, 1'b0);
        check_eq("nl_latency", window_valid, 1);
        idle(1);

        // reset in the middle of a fill
        run_pixels(60, 5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", window_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_window", window, '0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        run_pixels(70, 8, 1'b1);
        check_eq("postrst_no_valid", window_valid, 0);
        sb_q.push_back(exp_win(3, 70, 2));
        drive_px(78, 1'b0);
        check_eq("postrst_latency", window_valid, 1);
        idle(1);

        kernel_running = 1'b0;
        idle(2);
        check_eq("idle_busy", busy, 0);
        check_eq("sb_empty", WIN_BITS'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
